mdu_iter: RTL and testbench

//   Parametrised iterative multiply/divide unit with architectural HI/LO

---
 rtl/mdu_iter.sv | 206 ++++++++++++++++++++
 tb/tb_mdu_iter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// mult/multu use shift-add, div/divu use restoring shift-subtract; both
// iterate one bit per cycle, followed by a single sign-fix cycle.
// mthi/mtlo complete in one cycle without leaving IDLE.
module mdu_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int unsigned AW = 2 * WIDTH;

    localparam logic [2:0] OP_DIVU = 3'b011;
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [CNT_W-1:0]  counter;
    logic [AW-1:0]     acc;
    logic [WIDTH-1:0]  b_mag;
    logic [WIDTH-1:0]  a_raw;
    logic              is_div_q;
    logic              a_neg_q;
    logic              b_neg_q;

    logic              accept_arith;
    logic              accept_move;
    logic              last_iter;

    logic              a_neg_c;
    logic              b_neg_c;
    logic [WIDTH-1:0]  a_mag_c;
    logic [WIDTH-1:0]  b_mag_c;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic              div_ge;
    logic [WIDTH-1:0]  div_diff;
    logic [AW-1:0]     acc_step;

    logic [AW-1:0]     prod_fix;
    logic [WIDTH-1:0]  quo_fix;
    logic [WIDTH-1:0]  rem_fix;
    logic [WIDTH-1:0]  hi_fix;
    logic [WIDTH-1:0]  lo_fix;
    logic              div_by_zero;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and accept strobes
    always_comb begin
        state_next   = state;
        accept_arith = 1'b0;
        accept_move  = 1'b0;
        last_iter    = (counter == CNT_W'(WIDTH - 1));
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (op <= OP_DIVU) begin
                        accept_arith = 1'b1;
                        state_next   = S_RUN;
                    end else if ((op == OP_MTHI) || (op == OP_MTLO)) begin
                        accept_move = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand magnitudes, one iteration step, and final sign correction
    always_comb begin
        a_neg_c = ~op[0] & DataA[WIDTH-1];
        b_neg_c = ~op[0] & DataB[WIDTH-1];
        a_mag_c = a_neg_c ? (~DataA + WIDTH'(1)) : DataA;
        b_mag_c = b_neg_c ? (~DataB + WIDTH'(1)) : DataB;

        // Shift-add: conditionally add multiplicand to upper half, then shift right.
        mul_sum = {1'b0, acc[AW-1:WIDTH]} + {1'b0, (acc[0] ? b_mag : '0)};

        // Restoring divide: shift remainder left, subtract divisor if it fits.
        div_shift = {acc[AW-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_mag});
        div_diff  = div_shift[WIDTH-1:0] - b_mag;

        if (is_div_q) begin
            acc_step = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end

        prod_fix    = (a_neg_q ^ b_neg_q) ? (~acc + AW'(1)) : acc;
        quo_fix     = (a_neg_q ^ b_neg_q) ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
        rem_fix     = a_neg_q ? (~acc[AW-1:WIDTH] + WIDTH'(1)) : acc[AW-1:WIDTH];
        div_by_zero = (b_mag == '0);

        if (!is_div_q) begin
            hi_fix = prod_fix[AW-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end else if (div_by_zero) begin
            hi_fix = a_raw;
            lo_fix = '1;
        end else begin
            hi_fix = rem_fix;
            lo_fix = quo_fix;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
            counter  <= '0;
            acc      <= '0;
            b_mag    <= '0;
            a_raw    <= '0;
            is_div_q <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept_move) begin
                        if (op == OP_MTHI) begin
                            hi <= DataA;
                        end else begin
                            lo <= DataA;
                        end
                        done     <= 1'b1;
                        div_zero <= 1'b0;
                    end else if (accept_arith) begin
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                        counter  <= '0;
                        acc      <= {{WIDTH{1'b0}}, a_mag_c};
                        b_mag    <= b_mag_c;
                        a_raw    <= DataA;
                        is_div_q <= op[1];
                        a_neg_q  <= a_neg_c;
                        b_neg_q  <= b_neg_c;
                    end
                end
                S_RUN: begin
                    acc     <= acc_step;
                    counter <= counter + CNT_W'(1);
                end
                S_FIX: begin
                    hi      <= hi_fix;
                    lo      <= lo_fix;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    counter <= '0;
                    if (is_div_q && div_by_zero) begin
                        div_zero <= 1'b1;
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (WIDTH=32 and WIDTH=8 instances).
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] DataA;
    logic [31:0] DataB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;
    logic        dz8;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32), .CNT_W(6)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .DataA(DataA), .DataB(DataB),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    mdu_iter #(.WIDTH(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8),
        .DataA(a8), .DataB(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8)
    );

    // Count one comparison and report it if it differs
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request for one edge (called at a negedge), then scramble inputs
    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        DataA = a;
        DataB = b;
        @(negedge clk);
        start = 1'b0;
        op    = 3'b111;
        DataA = 32'hA5A5_5A5A;
        DataB = 32'h0F0F_F0F0;
    endtask

    // Wait for done; check latency, busy cycles and one-cycle pulse width
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy,
                             input int inject_at);
        int k  = 0;
        int bc = 0;
        bit seen = 1'b0;
        while (k <= 100) begin
            if (busy) bc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (k == inject_at) begin
                start = 1'b1;
                op    = MULTU;
                DataA = 32'd9;
                DataB = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 64'(seen ? k : -1), 64'(exp_lat));
        chk({tag, " busy cycles"}, 64'(bc), 64'(exp_busy));
        @(negedge clk);
        chk({tag, " done width"}, 64'(done), 64'd0);
    endtask

    // Full arithmetic op: launch, wait, compare hi/lo
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        launch(o, a, b);
        wait_done(tag, 33, 33, -1);
        chk({tag, " hi"}, 64'(hi), 64'(ehi));
        chk({tag, " lo"}, 64'(lo), 64'(elo));
    endtask

    initial begin
        int k;
        int dcnt;
        rst    = 1'b1;
        start  = 1'b0;
        op     = 3'b000;
        DataA  = '0;
        DataB  = '0;
        start8 = 1'b0;
        op8    = 3'b000;
        a8     = '0;
        b8     = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset div_zero", 64'(div_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Multiply cases
        run_op("mult -1*2", MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu ffffffff*2", MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);

        // mthi / mtlo: single cycle, busy never raised
        launch(MTHI, 32'h0000_1234, 32'd0);
        wait_done("mthi", 0, 0, -1);
        chk("mthi hi", 64'(hi), 64'h1234);
        chk("mthi lo kept", 64'(lo), 64'hFFFF_FFFE);
        launch(MTLO, 32'h0000_ABCD, 32'd0);
        wait_done("mtlo", 0, 0, -1);
        chk("mtlo lo", 64'(lo), 64'hABCD);
        chk("mtlo hi kept", 64'(hi), 64'h1234);

        run_op("multu max*max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult min*min", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("mult -3*5", MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // Divide cases
        run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 7/2", DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
        run_op("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_op("divu big", DIVU, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999);
        chk("div_zero clear", 64'(div_zero), 64'd0);

        // Divide by zero, then a mult clears the flag at its start edge
        run_op("divu 5/0", DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        chk("divu 5/0 flag", 64'(div_zero), 64'd1);
        launch(MULT, 32'd3, 32'd4);
        chk("div_zero cleared at start", 64'(div_zero), 64'd0);
        wait_done("mult 3*4", 33, 33, -1);
        chk("mult 3*4 lo", 64'(lo), 64'd12);
        chk("mult 3*4 hi", 64'(hi), 64'd0);
        run_op("div -5/0", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        chk("div -5/0 flag", 64'(div_zero), 64'd1);

        // Undefined op is ignored
        launch(3'b110, 32'd77, 32'd88);
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) dcnt++;
            @(negedge clk);
        end
        chk("op110 ignored", 64'(dcnt), 64'd0);
        chk("op110 hi kept", 64'(hi), 64'hFFFF_FFFB);

        // Start during busy is ignored
        launch(DIVU, 32'd100, 32'd7);
        wait_done("divu busy-start", 33, 33, 5);
        chk("divu busy-start hi", 64'(hi), 64'd2);
        chk("divu busy-start lo", 64'(lo), 64'd14);

        // Reset mid-operation
        launch(MULT, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst hi", 64'(hi), 64'd0);
        chk("midrst lo", 64'(lo), 64'd0);
        chk("midrst div_zero", 64'(div_zero), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("midrst no done", 64'(dcnt), 64'd0);

        // WIDTH=8: -128*-128, then a start the cycle after done
        start8 = 1'b1; op8 = MULT; a8 = 8'h80; b8 = 8'h80;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
        k = 0;
        while (!done8 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("w8 mult latency", 64'(k), 64'd9);
        chk("w8 mult result", 64'({hi8, lo8}), 64'h4000);
        @(negedge clk);
        start8 = 1'b1; op8 = MULTU; a8 = 8'hFF; b8 = 8'hFF;
        @(negedge clk);
        start8 = 1'b0;
        k = 0;
        while (!done8 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("w8 b2b latency", 64'(k), 64'd9);
        chk("w8 b2b result", 64'({hi8, lo8}), 64'hFE01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
